// File: rtl/lampfpu_sqrt_rndpack.sv
// lampfpu_sqrt_rndpack: round-to-nearest-even and pack of a square-root
// result into a 16-bit {s, e[7:0], frac[6:0]} word, buffered in a 2-entry
// FIFO with ready/valid handshake and a sticky drop indicator.
// Optional macro LAMPFPU_SQRT_RND_FLAGS_EN adds per-entry inexact_o / ovf_o.
module lampfpu_sqrt_rndpack (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_i,
   input  logic        s_res_i,
   input  logic [7:0]  e_res_i,
   input  logic [11:0] f_res_i,
   input  logic        isToRound_i,
   input  logic        ready_i,
   output logic        valid_o,
   output logic [15:0] res_o,
   output logic        full_o,
   output logic        drop_o
`ifdef LAMPFPU_SQRT_RND_FLAGS_EN
   ,
   output logic        inexact_o,
   output logic        ovf_o
`endif
);

   logic        guard_bit;
   logic        round_bit;
   logic        sticky_bit;
   logic        round_up;
   logic [8:0]  mant_inc;
   logic [8:0]  exp_inc;
   logic [15:0] word;
   logic        word_inexact;
   logic        word_ovf;
   logic        unused_bits;

   logic [15:0] mem_res [2];
   logic        wr_ptr;
   logic        rd_ptr;
   logic [1:0]  count;
   logic        drop_q;
   logic        do_push;
   logic        do_pop;

   assign guard_bit  = f_res_i[2];
   assign round_bit  = f_res_i[1];
   assign sticky_bit = f_res_i[0];
   assign round_up   = guard_bit & (round_bit | sticky_bit | f_res_i[3]);
   assign mant_inc   = {1'b0, f_res_i[10:3]} + 9'd1;
   assign exp_inc    = {1'b0, e_res_i} + 9'd1;

   // The overflow guard bit and the incremented hidden bit carry no
   // information into the packed word.
   assign unused_bits = f_res_i[11] ^ mant_inc[7];

   // Rounding and packing of the incoming result; specials pass through.
   always_comb begin
      word         = {s_res_i, e_res_i, f_res_i[9:3]};
      word_inexact = 1'b0;
      word_ovf     = 1'b0;
      if (isToRound_i) begin
         word_inexact = guard_bit | round_bit | sticky_bit;
         if (round_up) begin
            if (mant_inc[8]) begin
               // Carry out of the hidden bit: bump exponent, saturate to inf.
               if (exp_inc >= 9'h0FF) begin
                  word     = {s_res_i, 8'hFF, 7'd0};
                  word_ovf = 1'b1;
               end else begin
                  word = {s_res_i, exp_inc[7:0], 7'd0};
               end
            end else begin
               word = {s_res_i, e_res_i, mant_inc[6:0]};
            end
         end
      end
   end

   assign valid_o = (count != 2'd0);
   assign full_o  = (count == 2'd2);
   assign drop_o  = drop_q;
   assign res_o   = mem_res[rd_ptr];

   assign do_pop  = valid_o & ready_i;
   // A full buffer still accepts a push when the head leaves on the same edge.
   assign do_push = valid_i & (~full_o | do_pop);

   // FIFO storage, pointers, occupancy and sticky drop flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_res[0] <= 16'h0000;
         mem_res[1] <= 16'h0000;
         wr_ptr     <= 1'b0;
         rd_ptr     <= 1'b0;
         count      <= 2'd0;
         drop_q     <= 1'b0;
      end else begin
         if (do_push) begin
            mem_res[wr_ptr] <= word;
            wr_ptr          <= ~wr_ptr;
         end
         if (do_pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
         if (valid_i & ~do_push) begin
            drop_q <= 1'b1;
         end
      end
   end

`ifdef LAMPFPU_SQRT_RND_FLAGS_EN
   logic mem_inexact [2];
   logic mem_ovf     [2];

   assign inexact_o = mem_inexact[rd_ptr];
   assign ovf_o     = mem_ovf[rd_ptr];

   // Status flags travel with their result word through the FIFO.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_inexact[0] <= 1'b0;
         mem_inexact[1] <= 1'b0;
         mem_ovf[0]     <= 1'b0;
         mem_ovf[1]     <= 1'b0;
      end else if (do_push) begin
         mem_inexact[wr_ptr] <= word_inexact;
         mem_ovf[wr_ptr]     <= word_ovf;
      end
   end
`else
   logic unused_flags;
   assign unused_flags = word_inexact ^ word_ovf;
`endif

endmodule

// File: tb/tb_lampfpu_sqrt_rndpack.sv
// Self-checking bench for lampfpu_sqrt_rndpack: directed corner cases plus
// randomized traffic against a queue-based reference model.
module tb_lampfpu_sqrt_rndpack;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_i;
   logic        s_res_i;
   logic [7:0]  e_res_i;
   logic [11:0] f_res_i;
   logic        isToRound_i;
   logic        ready_i;
   logic        valid_o;
   logic [15:0] res_o;
   logic        full_o;
   logic        drop_o;
`ifdef LAMPFPU_SQRT_RND_FLAGS_EN
   logic        inexact_o;
   logic        ovf_o;
`endif

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [15:0] res;
      logic        inx;
      logic        ovf;
   } ent_t;

   ent_t q[$];
   logic m_drop;

   lampfpu_sqrt_rndpack dut (
      .clk         (clk),
      .rst         (rst),
      .valid_i     (valid_i),
      .s_res_i     (s_res_i),
      .e_res_i     (e_res_i),
      .f_res_i     (f_res_i),
      .isToRound_i (isToRound_i),
      .ready_i     (ready_i),
      .valid_o     (valid_o),
      .res_o       (res_o),
      .full_o      (full_o),
      .drop_o      (drop_o)
`ifdef LAMPFPU_SQRT_RND_FLAGS_EN
      ,
      .inexact_o   (inexact_o),
      .ovf_o       (ovf_o)
`endif
   );

   always #5 clk = ~clk;

   // Reference rounding: mantissa as an integer, remainder as an integer
   // out of 8; ties go to the even mantissa.
   function automatic ent_t ref_round(input logic s, input logic [7:0] e,
                                      input logic [11:0] f, input logic rnd);
      ent_t r;
      int m, rem, ex;
      logic [31:0] mv, exv;
      m   = int'(f[10:3]);
      rem = int'(f[2:0]);
      ex  = int'(e);
      r.inx = 1'b0;
      r.ovf = 1'b0;
      if (!rnd) begin
         r.res = {s, e, f[9:3]};
      end else begin
         r.inx = (rem != 0);
         if (rem > 4 || (rem == 4 && (m % 2) == 1)) begin
            m = m + 1;
            if (m == 256) begin
               m  = 0;
               ex = ex + 1;
               if (ex >= 255) begin
                  ex    = 255;
                  r.ovf = 1'b1;
               end
            end
         end
         mv    = m;
         exv   = ex;
         r.res = {s, exv[7:0], mv[6:0]};
      end
      return r;
   endfunction

   // Advance one clock edge and the model with it; outputs settle by #1.
   task automatic tick();
      bit pop, push;
      @(posedge clk);
      if (rst) begin
         q.delete();
         m_drop = 1'b0;
      end else begin
         pop  = (q.size() != 0) && ready_i;
         push = valid_i && ((q.size() < 2) || pop);
         if (pop) void'(q.pop_front());
         if (push) q.push_back(ref_round(s_res_i, e_res_i, f_res_i, isToRound_i));
         if (valid_i && !push) m_drop = 1'b1;
      end
      #1;
   endtask

   task automatic drive(input logic v, input logic s, input logic [7:0] e,
                        input logic [11:0] f, input logic rnd, input logic rdy);
      valid_i     = v;
      s_res_i     = s;
      e_res_i     = e;
      f_res_i     = f;
      isToRound_i = rnd;
      ready_i     = rdy;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b0, 1'b0, 8'h00, 12'h000, 1'b1, 1'b0);
      tick();
      tick();
      rst = 1'b0;
      checks++;
      if (valid_o !== 1'b0 || full_o !== 1'b0 || drop_o !== 1'b0 || res_o !== 16'h0000) begin
         failures++;
         $display("FAIL reset_state: valid=%b full=%b drop=%b res=%h, required 0 0 0 0000",
                  valid_o, full_o, drop_o, res_o);
      end
`ifdef LAMPFPU_SQRT_RND_FLAGS_EN
      checks++;
      if (inexact_o !== 1'b0 || ovf_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_flags: inexact=%b ovf=%b, required 0 0", inexact_o, ovf_o);
      end
`endif
   endtask

   task automatic test_rounding();
      logic [15:0] exp_res [5];
      logic [7:0]  e_tab   [5];
      logic [11:0] f_tab   [5];
      logic        s_tab   [5];
      logic        r_tab   [5];
      logic        inx_tab [5];
      logic        ovf_tab [5];
      e_tab = '{8'h7F, 8'h7F, 8'h7F, 8'hFE, 8'hFF};
      f_tab = '{12'h404, 12'h40C, 12'h7FE, 12'h7FE, 12'h208};
      s_tab = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      r_tab = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      exp_res = '{16'h3F80, 16'h3F82, 16'h4000, 16'h7F80, 16'hFFC1};
      inx_tab = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      ovf_tab = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, s_tab[i], e_tab[i], f_tab[i], r_tab[i], 1'b1);
         tick();
         drive(1'b0, 1'b0, 8'h00, 12'h000, 1'b1, 1'b1);
         checks++;
         if (valid_o !== 1'b1 || res_o !== exp_res[i]) begin
            failures++;
            $display("FAIL round_case%0d: valid=%b res=%h, required 1 %h",
                     i, valid_o, res_o, exp_res[i]);
         end
`ifdef LAMPFPU_SQRT_RND_FLAGS_EN
         checks++;
         if (inexact_o !== inx_tab[i] || ovf_o !== ovf_tab[i]) begin
            failures++;
            $display("FAIL flags_case%0d: inexact=%b ovf=%b, required %b %b",
                     i, inexact_o, ovf_o, inx_tab[i], ovf_tab[i]);
         end
`endif
         tick();
         checks++;
         if (valid_o !== 1'b0) begin
            failures++;
            $display("FAIL drain_case%0d: valid=%b, required 0", i, valid_o);
         end
      end
   endtask

   task automatic test_backpressure();
      drive(1'b1, 1'b0, 8'h10, 12'h408, 1'b1, 1'b0);   // A -> 0x0801
      tick();
      drive(1'b1, 1'b0, 8'h20, 12'h410, 1'b1, 1'b0);   // B -> 0x1002
      tick();
      drive(1'b1, 1'b0, 8'h30, 12'h418, 1'b1, 1'b0);   // C dropped
      tick();
      drive(1'b0, 1'b0, 8'h00, 12'h000, 1'b1, 1'b0);
      checks++;
      if (full_o !== 1'b1 || drop_o !== 1'b1 || res_o !== 16'h0801) begin
         failures++;
         $display("FAIL bp_full: full=%b drop=%b res=%h, required 1 1 0801", full_o, drop_o, res_o);
      end
      tick();
      checks++;
      if (res_o !== 16'h0801 || valid_o !== 1'b1) begin
         failures++;
         $display("FAIL bp_hold: valid=%b res=%h, required 1 0801", valid_o, res_o);
      end
      ready_i = 1'b1;
      tick();
      checks++;
      if (valid_o !== 1'b1 || res_o !== 16'h1002 || full_o !== 1'b0) begin
         failures++;
         $display("FAIL bp_second: valid=%b full=%b res=%h, required 1 0 1002", valid_o, full_o, res_o);
      end
      tick();
      checks++;
      if (valid_o !== 1'b0 || drop_o !== 1'b1) begin
         failures++;
         $display("FAIL bp_no_c: valid=%b drop=%b, required 0 1", valid_o, drop_o);
      end
   endtask

   task automatic test_full_push_pop();
      test_reset();
      drive(1'b1, 1'b0, 8'h40, 12'h400, 1'b1, 1'b0);   // 0x2000
      tick();
      drive(1'b1, 1'b0, 8'h41, 12'h400, 1'b1, 1'b0);   // 0x2080
      tick();
      drive(1'b1, 1'b0, 8'h42, 12'h400, 1'b1, 1'b1);   // 0x2100, same-edge pop
      tick();
      drive(1'b0, 1'b0, 8'h00, 12'h000, 1'b1, 1'b0);
      checks++;
      if (full_o !== 1'b1 || drop_o !== 1'b0 || res_o !== 16'h2080) begin
         failures++;
         $display("FAIL full_pushpop: full=%b drop=%b res=%h, required 1 0 2080", full_o, drop_o, res_o);
      end
      ready_i = 1'b1;
      tick();
      checks++;
      if (res_o !== 16'h2100 || valid_o !== 1'b1) begin
         failures++;
         $display("FAIL full_pushpop_tail: valid=%b res=%h, required 1 2100", valid_o, res_o);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      drive(1'b1, 1'b0, 8'h50, 12'h400, 1'b1, 1'b0);
      tick();
      tick();
      rst = 1'b1;
      drive(1'b1, 1'b0, 8'h51, 12'h400, 1'b1, 1'b1);
      tick();
      rst = 1'b0;
      drive(1'b0, 1'b0, 8'h00, 12'h000, 1'b1, 1'b1);
      checks++;
      if (valid_o !== 1'b0 || full_o !== 1'b0 || drop_o !== 1'b0 || res_o !== 16'h0000) begin
         failures++;
         $display("FAIL reset_mid: valid=%b full=%b drop=%b res=%h, required 0 0 0 0000",
                  valid_o, full_o, drop_o, res_o);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (valid_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_stale%0d: valid=%b, required 0", i, valid_o);
         end
      end
   endtask

   task automatic test_random();
      logic rnd;
      for (int n = 0; n < 2000; n++) begin
         rnd = ($urandom_range(0, 7) != 0);
         drive(($urandom_range(0, 1) == 1), 1'($urandom()),
               rnd ? 8'($urandom_range(0, 254)) : 8'($urandom()),
               12'($urandom()), rnd, ($urandom_range(0, 9) < 6));
         tick();
         checks++;
         if (valid_o !== (q.size() != 0) || full_o !== (q.size() == 2) || drop_o !== m_drop) begin
            failures++;
            $display("FAIL rand_status n=%0d: valid=%b full=%b drop=%b, required %b %b %b",
                     n, valid_o, full_o, drop_o, (q.size() != 0), (q.size() == 2), m_drop);
         end
         if (q.size() != 0) begin
            checks++;
            if (res_o !== q[0].res) begin
               failures++;
               $display("FAIL rand_res n=%0d: res=%h, required %h", n, res_o, q[0].res);
            end
`ifdef LAMPFPU_SQRT_RND_FLAGS_EN
            checks++;
            if (inexact_o !== q[0].inx || ovf_o !== q[0].ovf) begin
               failures++;
               $display("FAIL rand_flags n=%0d: inexact=%b ovf=%b, required %b %b",
                        n, inexact_o, ovf_o, q[0].inx, q[0].ovf);
            end
`endif
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 1'b0, 8'h00, 12'h000, 1'b1, 1'b0);
      m_drop = 1'b0;
      test_reset();
      test_rounding();
      test_backpressure();
      test_full_push_pop();
      test_reset_mid();
      test_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lampfpu_sqrt_rndpack.md
LAMPFPU_SQRT_RNDPACK -- requirements
Module: lampfpu_sqrt_rndpack

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port valid_i, input, 1, one-cycle pulse marking a sqrt result on the inputs.
REQ-004 SHALL have port s_res_i, input, 1, result sign.
REQ-005 SHALL have port e_res_i, input, 8, biased result exponent.
REQ-006 SHALL have port f_res_i, input, 12, layout {ovf guard[11], hidden[10], frac[9:3], G[2], R[1], S[0]}.
REQ-007 SHALL have port isToRound_i, input, 1, 1=apply rounding; 0=special value, pass through.
REQ-008 SHALL have port ready_i, input, 1, downstream accepts the head entry when high with valid_o.
REQ-009 SHALL have port valid_o, output, 1, head entry present.
REQ-010 SHALL have port res_o, output, 16, packed {s, e[7:0], frac[6:0]}.
REQ-011 SHALL have port full_o, output, 1, buffer holds 2 entries.
REQ-012 SHALL have port drop_o, output, 1, sticky: an input was lost because the buffer was full.

Function
REQ-013 SHALL compute RNE on valid_i: round up iff G & (R | S | frac[3]).
REQ-014 SHALL increment {hidden, frac} on round-up; a carry out of hidden SHALL give e+1 with frac=0.
REQ-015 SHALL output e=0xFF, frac=0 (infinity, sign kept) when the increment makes e reach 0xFF.
REQ-016 SHALL pack {s_res_i, e_res_i, f_res_i[9:3]} unchanged when isToRound_i=0.
REQ-017 SHALL write the packed word into a 2-entry FIFO at the clock edge where valid_i=1.
REQ-018 SHALL give latency one cycle: valid_i at edge N with the FIFO empty gives valid_o=1 and res_o valid after edge N.
REQ-019 SHALL drive res_o from the FIFO head register only, with no combinational path from inputs.
REQ-020 SHALL pop the head on any edge with valid_o & ready_i, and SHALL keep res_o stable while valid_o & ~ready_i.
REQ-021 SHALL accept push and pop on the same edge when the FIFO is full, with occupancy unchanged and no drop.
REQ-022 SHALL treat push while full without pop as a discard, set drop_o, and leave the stored entries unchanged.
REQ-023 SHALL hold drop_o until reset.
REQ-024 SHALL keep order FIFO; read/write pointers SHALL wrap modulo 2, and occupancy SHALL be a 2-bit count in 0..2.
REQ-025 SHALL assert full_o exactly when the count is 2; valid_o SHALL be asserted exactly when the count is nonzero.

Reset
REQ-026 SHALL, on rst at an edge, clear count, pointers, valid_o, full_o and drop_o, and set res_o=16'h0000.
REQ-027 SHALL discard all buffered entries on rst mid-operation, ignoring valid_i and ready_i during that edge.

Configuration
REQ-028 SHALL, with macro LAMPFPU_SQRT_RND_FLAGS_EN defined, add outputs inexact_o (G|R|S of the rounded entry) and ovf_o (REQ-015 occurred).
REQ-029 SHALL store inexact_o and ovf_o per entry in the FIFO, aligned with res_o, and force both to 0 when isToRound_i=0; both SHALL reset to 0.
REQ-030 SHALL, without LAMPFPU_SQRT_RND_FLAGS_EN, omit inexact_o and ovf_o and their storage; all other behaviour SHALL be identical.

Verification
REQ-031 SHALL cover a tie with even LSB: s=0, e=0x7F, f=0x404, ready_i=1 -> next cycle valid_o=1, res_o=0x3F80, inexact_o=1.
REQ-032 SHALL cover a tie with odd LSB: e=0x7F, f=0x40C -> res_o=0x3F82.
REQ-033 SHALL cover mantissa carry: e=0x7F, f=0x7FE -> res_o=0x4000; with e=0xFE -> res_o=0x7F80, ovf_o=1.
REQ-034 SHALL cover passthrough: isToRound_i=0, s=1, e=0xFF, f=0x208 -> res_o=0xFFC1, inexact_o=0, ovf_o=0.
REQ-035 SHALL cover backpressure: ready_i=0 with 3 valid_i pulses A, B, C -> full_o=1, drop_o=1, then ready_i=1 -> A then B output, C never output.
REQ-036 SHALL cover reset mid-operation: 2 entries held, rst for 1 cycle -> valid_o=0, full_o=0, drop_o=0, res_o=0x0000, and no stale entry on the following cycles.
